// File: rtl/systolic_sched_ctrl.sv
// systolic_sched_ctrl: sequences one KxK multiply job (load, stream, drain, done) for the feeders and PE array.
// Define SA_CTRL_PERF_EN to build the saturating perf_jobs / perf_busy_cycles counters.
module systolic_sched_ctrl #(
    parameter int NUM_ELEMENTS = 6,
    parameter int DRAIN_CYCLES = 2 * NUM_ELEMENTS,
    parameter int CNT_WIDTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        abort,
    output logic        piso_start,
    output logic        acc_clear,
    output logic        stream_active,
    output logic        pe_enable,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [31:0] perf_jobs,
    output logic [31:0] perf_busy_cycles
);
    localparam int STREAM_CYCLES = 3 * NUM_ELEMENTS;
    localparam int MAX_CNT = (STREAM_CYCLES > DRAIN_CYCLES) ? STREAM_CYCLES : DRAIN_CYCLES;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    if (DRAIN_CYCLES < 1 || CNT_WIDTH < 1 || (CNT_WIDTH < 32 && (MAX_CNT >> CNT_WIDTH) != 0)) begin : g_param_check
        $error("systolic_sched_ctrl: CNT_WIDTH too small or DRAIN_CYCLES < 1");
    end

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic cmd_ready_q, cmd_ready_d, piso_start_q, piso_start_d, acc_clear_q, acc_clear_d;
    logic stream_active_q, stream_active_d, pe_enable_q, pe_enable_d, busy_q, busy_d;
    logic done_q, done_d, aborted_q, aborted_d;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cmd_ready_d     = cmd_ready_q;
        busy_d          = busy_q;
        stream_active_d = stream_active_q;
        pe_enable_d     = pe_enable_q;
        piso_start_d    = 1'b0;
        acc_clear_d     = 1'b0;
        done_d          = 1'b0;
        aborted_d       = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                state_d      = S_LOAD;
                cmd_ready_d  = 1'b0;
                busy_d       = 1'b1;
                piso_start_d = 1'b1;
                acc_clear_d  = 1'b1;
            end
            S_LOAD: begin
                state_d         = S_STREAM;
                stream_active_d = 1'b1;
                pe_enable_d     = 1'b1;
                cnt_d           = CNT_WIDTH'(STREAM_CYCLES - 1);
            end
            S_STREAM: if (cnt_q == '0) begin
                state_d         = S_DRAIN;
                stream_active_d = 1'b0;
                cnt_d           = CNT_WIDTH'(DRAIN_CYCLES - 1);
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
            S_DRAIN: if (cnt_q == '0) begin
                state_d     = S_DONE;
                pe_enable_d = 1'b0;
                done_d      = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
        // Abort reuses DONE as its one-cycle exit so busy drops on the following edge; it beats a coincident done.
        if (abort && (state_q == S_LOAD || state_q == S_STREAM || state_q == S_DRAIN)) begin
            state_d         = S_DONE;
            aborted_d       = 1'b1;
            acc_clear_d     = 1'b1;
            piso_start_d    = 1'b0;
            stream_active_d = 1'b0;
            pe_enable_d     = 1'b0;
            done_d          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            cmd_ready_q     <= 1'b1;
            piso_start_q    <= 1'b0;
            acc_clear_q     <= 1'b0;
            stream_active_q <= 1'b0;
            pe_enable_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cmd_ready_q     <= cmd_ready_d;
            piso_start_q    <= piso_start_d;
            acc_clear_q     <= acc_clear_d;
            stream_active_q <= stream_active_d;
            pe_enable_q     <= pe_enable_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            aborted_q       <= aborted_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign piso_start    = piso_start_q;
    assign acc_clear     = acc_clear_q;
    assign stream_active = stream_active_q;
    assign pe_enable     = pe_enable_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;

`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_jobs_q, perf_jobs_d, perf_busy_q, perf_busy_d;

    always_comb begin
        perf_jobs_d = (done_q && perf_jobs_q != '1) ? perf_jobs_q + 32'd1 : perf_jobs_q;
        perf_busy_d = (busy_q && perf_busy_q != '1) ? perf_busy_q + 32'd1 : perf_busy_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_jobs_q <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_jobs_q <= perf_jobs_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_jobs        = perf_jobs_q;
    assign perf_busy_cycles = perf_busy_q;
`else
    assign perf_jobs        = '0;
    assign perf_busy_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_sched_ctrl.sv
// tb_systolic_sched_ctrl: randomized scoreboard bench; expected outputs derived from job-relative cycle offsets.
module tb_systolic_sched_ctrl;
    localparam int K    = 4;
    localparam int D    = 8;
    localparam int LAST = 3 * K + D + 1;

    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
    logic cmd_ready, piso_start, acc_clear, stream_active, pe_enable, busy, done, aborted;
    logic [31:0] perf_jobs, perf_busy_cycles;

    systolic_sched_ctrl #(.NUM_ELEMENTS(K), .DRAIN_CYCLES(D), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
        .piso_start(piso_start), .acc_clear(acc_clear), .stream_active(stream_active),
        .pe_enable(pe_enable), .busy(busy), .done(done), .aborted(aborted),
        .perf_jobs(perf_jobs), .perf_busy_cycles(perf_busy_cycles)
    );

    always #5 clk = ~clk;

    logic [71:0] exp_q[$];
    int checks = 0, errors = 0;

    // Reference: a job is (accept edge e0, abort offset ab); outputs follow from offset o = edge - e0.
    int n = 0, e0 = 0, ab = -1;
    bit in_job = 0;
    logic [7:0] prev = 8'h80;
    logic [31:0] pj = 0, pb = 0;

    always @(posedge clk) begin
        logic [7:0] v;
        int o;
        if (rst) begin
            in_job = 0;
            pj = 0;
            pb = 0;
            v = 8'h80;
        end else begin
`ifdef SA_CTRL_PERF_EN
            if (prev[1] && pj != 32'hFFFF_FFFF) pj = pj + 1;
            if (prev[2] && pb != 32'hFFFF_FFFF) pb = pb + 1;
`endif
            if (in_job) begin
                o = n - e0;
                if (o == ((ab >= 0) ? ab + 1 : LAST + 1)) in_job = 0;
                else if (ab < 0 && abort) ab = o;
            end else if (cmd_valid) begin
                in_job = 1;
                e0 = n;
                ab = -1;
            end
            if (!in_job) v = 8'h80;
            else begin
                o = n - e0;
                if (o == ab) v = 8'b0010_0101;
                else v = {1'b0, o == 0, o == 0, (o >= 1 && o <= 3 * K), (o >= 1 && o <= 3 * K + D),
                          1'b1, o == LAST, 1'b0};
            end
        end
        prev = v;
        exp_q.push_back({v, pj, pb});
        n++;
    end

    always @(negedge clk) begin
        logic [71:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {cmd_ready, piso_start, acc_clear, stream_active, pe_enable, busy, done, aborted,
                 perf_jobs, perf_busy_cycles};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs edge %0d: got rdy/piso/clr/strm/pe/busy/done/abt=%b perf=%h/%h, expected %b perf=%h/%h",
                         n - 1, a[71:64], a[63:32], a[31:0], e[71:64], e[63:32], e[31:0]);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic job_abort(input int a);
        cmd_valid = 1;
        step(1);
        cmd_valid = 0;
        step(a - 1);
        abort = 1;
        step(1);
        abort = 0;
        step(30);
    endtask

    initial begin
        step(3);
        rst = 0;
        step(10);
        cmd_valid = 1;
        step(1);
        cmd_valid = 0;
        step(30);
        cmd_valid = 1;
        step(50);
        cmd_valid = 0;
        step(30);
        job_abort(5);
        job_abort(1);
        job_abort(LAST + 1);
        cmd_valid = 1;
        step(1);
        cmd_valid = 0;
        step(LAST - 1);
        abort = 1;
        step(1);
        abort = 0;
        cmd_valid = 1;
        step(2);
        cmd_valid = 0;
        step(30);
        abort = 1;
        step(3);
        cmd_valid = 1;
        step(1);
        cmd_valid = 0;
        abort = 0;
        step(30);
        cmd_valid = 1;
        step(1);
        cmd_valid = 0;
        step(9);
        rst = 1;
        step(1);
        rst = 0;
        step(3);
        cmd_valid = 1;
        step(1);
        cmd_valid = 0;
        step(30);
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 249) == 0);
            step(1);
        end
        cmd_valid = 0;
        abort = 0;
        rst = 0;
        step(30);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
